// File: rtl/pipe_acc_pkg.sv
// Shared types, default widths and helpers for the pipelined-adder sum accumulator.
package pipe_acc_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } acc_state_t;

    localparam int SUM_WIDTH_DEF = 64;
    localparam int ACC_WIDTH_DEF = 80;
    localparam int CNT_WIDTH_DEF = 8;
    localparam int CNT_MAX_WIDTH = 32;

    // Counters up to CNT_MAX_WIDTH bits share this helper; callers size-cast in and out.
    function automatic logic [CNT_MAX_WIDTH-1:0] sat_inc(
        input logic [CNT_MAX_WIDTH-1:0] value,
        input logic [CNT_MAX_WIDTH-1:0] limit
    );
        return (value >= limit) ? value : value + CNT_MAX_WIDTH'(1);
    endfunction

endpackage

// File: rtl/acc_bank.sv
// One accumulator bank: running sum, saturating beat count, sticky overflow and a
// completion flag that holds the bank frozen until it is cleared.
module acc_bank
    import pipe_acc_pkg::*;
#(
    parameter int WIDTH     = SUM_WIDTH_DEF,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 add,
    input  logic                 last,
    input  logic [WIDTH:0]       beat,
    output logic                 full,
    output logic [ACC_WIDTH-1:0] acc_next,
    output logic [CNT_WIDTH-1:0] count_next,
    output logic                 ovf_next
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [ACC_WIDTH-1:0] acc;
    logic [CNT_WIDTH-1:0] count;
    logic                 ovf;
    logic [ACC_WIDTH:0]   sum_wide;

    // The extra top bit of sum_wide is the carry out of the accumulator width.
    assign sum_wide = {1'b0, acc} + {1'b0, ACC_WIDTH'(beat)};

    always_comb begin
        acc_next   = acc;
        count_next = count;
        ovf_next   = ovf;
        if (add) begin
            acc_next   = sum_wide[ACC_WIDTH-1:0];
            count_next = CNT_WIDTH'(sat_inc(CNT_MAX_WIDTH'(count), CNT_MAX_WIDTH'(CNT_MAX)));
            ovf_next   = ovf | sum_wide[ACC_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
            full  <= 1'b0;
        end else begin
            acc   <= acc_next;
            count <= count_next;
            ovf   <= ovf_next;
            if (add && last) begin
                full <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_sum_accumulator.sv
// Accumulates bursts of pipelined-adder results and hands each total off over valid/ready.
// Define PIPE_ACC_PINGPONG_EN for a second bank that keeps accepting while a total waits.
module pipe_sum_accumulator
    import pipe_acc_pkg::*;
#(
    parameter int WIDTH     = SUM_WIDTH_DEF,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_sum,
    input  logic                 in_cout,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_acc,
    output logic [CNT_WIDTH-1:0] out_count,
    output logic                 out_ovf,
    output logic                 drop_err
);

`ifdef PIPE_ACC_PINGPONG_EN
    localparam int NBANK = 2;
`else
    localparam int NBANK = 1;
`endif
    localparam bit PP = (NBANK == 2);

    acc_state_t state;
    logic       wr_sel;
    logic       rd_sel;
    logic [WIDTH:0] beat;
    logic       accept;
    logic       handshake;
    logic       completing;

    logic [ACC_WIDTH-1:0] bank_acc_next   [NBANK];
    logic [CNT_WIDTH-1:0] bank_count_next [NBANK];
    logic                 bank_ovf_next   [NBANK];
    logic                 bank_full       [NBANK];

    logic                 wr_hi;
    logic                 oth_hi;
    logic                 oth_full;
    logic                 oth_valid;
    logic [ACC_WIDTH-1:0] wr_acc;
    logic [CNT_WIDTH-1:0] wr_count;
    logic                 wr_ovf;
    logic [ACC_WIDTH-1:0] oth_acc;
    logic [CNT_WIDTH-1:0] oth_count;
    logic                 oth_ovf;
    logic                 full_next_lo;
    logic                 full_next_hi;
    logic                 wr_sel_next;
    logic                 in_ready_next;

    assign beat       = {in_cout, in_sum};
    assign accept     = in_valid && in_ready;
    assign handshake  = out_valid && out_ready;
    assign completing = accept && in_last;
    assign out_valid  = (state == DONE);

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        acc_bank #(
            .WIDTH     (WIDTH),
            .ACC_WIDTH (ACC_WIDTH),
            .CNT_WIDTH (CNT_WIDTH)
        ) u_bank (
            .clk        (clk),
            .rst        (rst),
            .clear      (handshake && (rd_sel == 1'(b))),
            .add        (accept && (wr_sel == 1'(b))),
            .last       (in_last),
            .beat       (beat),
            .full       (bank_full[b]),
            .acc_next   (bank_acc_next[b]),
            .count_next (bank_count_next[b]),
            .ovf_next   (bank_ovf_next[b])
        );
    end

    // "oth" is the bank not currently presented; with one bank it never qualifies.
    assign wr_hi     = PP && wr_sel;
    assign oth_hi    = PP && !rd_sel;
    assign oth_full  = oth_hi ? bank_full[NBANK-1] : bank_full[0];
    assign oth_valid = PP && (oth_full || completing);

    always_comb begin
        wr_acc    = bank_acc_next[0];
        wr_count  = bank_count_next[0];
        wr_ovf    = bank_ovf_next[0];
        oth_acc   = bank_acc_next[0];
        oth_count = bank_count_next[0];
        oth_ovf   = bank_ovf_next[0];
        if (wr_hi) begin
            wr_acc   = bank_acc_next[NBANK-1];
            wr_count = bank_count_next[NBANK-1];
            wr_ovf   = bank_ovf_next[NBANK-1];
        end
        if (oth_hi) begin
            oth_acc   = bank_acc_next[NBANK-1];
            oth_count = bank_count_next[NBANK-1];
            oth_ovf   = bank_ovf_next[NBANK-1];
        end
    end

    // in_ready is registered: it reflects whether the bank written next cycle will be free.
    assign full_next_lo  = (bank_full[0] && !(handshake && !rd_sel)) || (completing && !wr_sel);
    assign full_next_hi  = PP && ((bank_full[NBANK-1] && !(handshake && rd_sel))
                                  || (completing && wr_sel));
    assign wr_sel_next   = PP && (wr_sel ^ completing);
    assign in_ready_next = !(wr_sel_next ? full_next_hi : full_next_lo);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            wr_sel    <= 1'b0;
            rd_sel    <= 1'b0;
            in_ready  <= 1'b1;
            out_acc   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
            drop_err  <= 1'b0;
        end else begin
            in_ready <= in_ready_next;
            wr_sel   <= wr_sel_next;
            if (in_valid && !in_ready) begin
                drop_err <= 1'b1;
            end
            case (state)
                ACCUM: begin
                    if (completing) begin
                        state     <= DONE;
                        rd_sel    <= wr_sel;
                        out_acc   <= wr_acc;
                        out_count <= wr_count;
                        out_ovf   <= wr_ovf;
                    end
                end
                DONE: begin
                    if (handshake) begin
                        if (oth_valid) begin
                            rd_sel    <= !rd_sel;
                            out_acc   <= oth_acc;
                            out_count <= oth_count;
                            out_ovf   <= oth_ovf;
                        end else begin
                            state     <= ACCUM;
                            out_acc   <= '0;
                            out_count <= '0;
                            out_ovf   <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule
